// File: rtl/keypad_pkg.sv
// Shared keypad definitions for the scanner and the row debouncer.
//   scan_state_t : scanner FSM states
//   NUM_ROWS     : keypad row count, also used by the debouncer
package keypad_pkg;

  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/keypad_scanner_if.sv
// Scanner-side bundle between the keypad and the row debouncer.
//   scanEn   : scan enable (into scanner)
//   rowIn    : raw asynchronous keypad rows (into scanner)
//   colDrive : one-hot column strobe (from scanner)
//   en       : one-cycle sample strobe (from scanner)
//   column   : column index belonging to row (from scanner)
//   row      : synchronized row snapshot (from scanner)
// master = the scanner, slave = whoever drives enable/rows and consumes strobes.
interface keypad_scanner_if
  import keypad_pkg::*;
#(
  parameter int NUM_COLS = 2
) ();
  localparam int COL_W = $clog2(NUM_COLS);

  logic                scanEn;
  logic [NUM_ROWS-1:0] rowIn;
  logic [NUM_COLS-1:0] colDrive;
  logic                en;
  logic [COL_W-1:0]    column;
  logic [NUM_ROWS-1:0] row;

  modport master (
    input  scanEn, rowIn,
    output colDrive, en, column, row
  );

  modport slave (
    output scanEn, rowIn,
    input  colDrive, en, column, row
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer, parameterized width, synchronous active-high reset.
//   clk, rst : clock and synchronous reset
//   d_i      : asynchronous input
//   q_o      : synchronized output (two cycles of latency)
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// Column-strobe keypad scanner. Drives one column at a time for
// SETTLE_CYCLES cycles, then spends one SAMPLE cycle presenting the
// synchronized rows with an en strobe and the column index.
//   clk, rst : clock and synchronous active-high reset
//   bus      : keypad_scanner_if.master (scanEn/rowIn in; colDrive/en/column/row out)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_COLS      = 2,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  bus
);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int CNT_W = $clog2(SETTLE_CYCLES);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

  scan_state_t         state_q,  state_d;
  logic [COL_W-1:0]    colIdx_q, colIdx_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [COL_W-1:0]    column_q, column_d;
  logic [NUM_ROWS-1:0] row_q,    row_d;
  logic [NUM_ROWS-1:0] rowSync;

  sync2 #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rowIn),
    .q_o (rowSync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      colIdx_q <= '0;
      cnt_q    <= '0;
      column_q <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      colIdx_q <= colIdx_d;
      cnt_q    <= cnt_d;
      column_q <= column_d;
      row_q    <= row_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    colIdx_d = colIdx_q;
    cnt_d    = cnt_q;
    column_d = column_q;
    row_d    = row_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.scanEn) state_d = SETTLE;
      end
      SETTLE: begin
        // Abort takes priority over the final settle count: a column whose
        // enable dropped is never strobed, and is re-driven in full later.
        if (!bus.scanEn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = SAMPLE;
          cnt_d    = '0;
          row_d    = rowSync;
          column_d = colIdx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        // scanEn only decides where to go after the strobe, never cancels it.
        colIdx_d = (colIdx_q == COL_LAST) ? '0 : colIdx_q + 1'b1;
        cnt_d    = '0;
        state_d  = bus.scanEn ? SETTLE : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode registered state only; nothing combinational from inputs.
  assign bus.colDrive = (state_q != IDLE) ? (NUM_COLS'(1) << colIdx_q) : '0;
  assign bus.en       = (state_q == SAMPLE);
  assign bus.column   = column_q;
  assign bus.row      = row_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int NC = 2;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if #(.NUM_COLS(NC)) bus ();

  keypad_scanner #(.NUM_COLS(NC), .SETTLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       scanEn;
    logic [3:0] rowIn;
    logic [1:0] colDrive;
    logic       en;
    logic       column;
    logic [3:0] row;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic add(input logic r, input logic s, input logic [3:0] ri,
                     input logic [1:0] cd, input logic e, input logic c,
                     input logic [3:0] ro);
    vec_t v;
    v.rst = r; v.scanEn = s; v.rowIn = ri;
    v.colDrive = cd; v.en = e; v.column = c; v.row = ro;
    vecs.push_back(v);
  endtask

  task automatic addn(input int n, input logic r, input logic s, input logic [3:0] ri,
                      input logic [1:0] cd, input logic e, input logic c,
                      input logic [3:0] ro);
    for (int i = 0; i < n; i++) add(r, s, ri, cd, e, c, ro);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    logic exp_col;
    bus.scanEn = 1'b0;
    bus.rowIn  = 4'h0;

    // 1. reset hold with scan enabled and rows high
    addn(10, 1, 1, 4'hF, 2'b00, 0, 0, 4'h0);
    // 2/3. free-running scan, column 0 then column 1 capturing 0100
    addn(4,  0, 1, 4'h0, 2'b01, 0, 0, 4'h0);
    add (    0, 1, 4'h0, 2'b01, 1, 0, 4'h0);
    addn(4,  0, 1, 4'h4, 2'b10, 0, 0, 4'h0);
    add (    0, 1, 4'h4, 2'b10, 1, 1, 4'h4);
    // column 0 wraps; rowIn changes one cycle before SAMPLE and is missed
    addn(3,  0, 1, 4'h4, 2'b01, 0, 1, 4'h4);
    add (    0, 1, 4'h1, 2'b01, 0, 1, 4'h4);
    add (    0, 1, 4'h1, 2'b01, 1, 0, 4'h4);
    // 4. abort column 1 at cnt=2, then re-drive it in full
    addn(3,  0, 1, 4'h1, 2'b10, 0, 0, 4'h4);
    addn(2,  0, 0, 4'h1, 2'b00, 0, 0, 4'h4);
    addn(4,  0, 1, 4'h1, 2'b10, 0, 0, 4'h4);
    add (    0, 1, 4'h1, 2'b10, 1, 1, 4'h1);
    // 5. scanEn dropped during SAMPLE of column 0
    addn(4,  0, 1, 4'h8, 2'b01, 0, 1, 4'h1);
    add (    0, 1, 4'h8, 2'b01, 1, 0, 4'h8);
    addn(2,  0, 0, 4'h2, 2'b00, 0, 0, 4'h8);
    addn(4,  0, 1, 4'h2, 2'b10, 0, 0, 4'h8);
    add (    0, 1, 4'h2, 2'b10, 1, 1, 4'h2);
    // 6. reset during SAMPLE of column 1, restart at column 0
    add (    1, 1, 4'h2, 2'b00, 0, 0, 4'h0);
    addn(4,  0, 1, 4'h2, 2'b01, 0, 0, 4'h0);
    add (    0, 1, 4'h2, 2'b01, 1, 0, 4'h2);

    foreach (vecs[i]) begin
      rst        = vecs[i].rst;
      bus.scanEn = vecs[i].scanEn;
      bus.rowIn  = vecs[i].rowIn;
      tick();
      nvec++;
      if (bus.colDrive !== vecs[i].colDrive || bus.en !== vecs[i].en ||
          bus.column !== vecs[i].column || bus.row !== vecs[i].row ||
          !$onehot0(bus.colDrive)) begin
        nerr++;
        $display("FAIL vec%0d: colDrive=%b en=%b column=%0d row=%b, want colDrive=%b en=%b column=%0d row=%b",
                 i, bus.colDrive, bus.en, bus.column, bus.row,
                 vecs[i].colDrive, vecs[i].en, vecs[i].column, vecs[i].row);
      end
    end

    // strobe period and column alternation with scanEn held high
    exp_col = 1'b1;
    for (int p = 0; p < 3; p++) begin
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (bus.en !== 1'b1 && cyc < 20);
      nvec++;
      if (cyc != SC + 1 || bus.column !== exp_col) begin
        nerr++;
        $display("FAIL period%0d: cycles=%0d column=%0d, want cycles=%0d column=%0d",
                 p, cyc, bus.column, SC + 1, exp_col);
      end
      exp_col = ~exp_col;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
